// File: rtl/vga_source_mux.sv
`default_nettype none
// ============================================================================
// Module   : vga_source_mux
// Purpose  : Registered pixel-source selector for the VGA driver. Picks one
//            of NUM_SOURCES colour generators and forces black during
//            blanking. A source change request is held until the next frame
//            start, so one frame always comes from a single source.
// Ports    : clk, reset        - system clock, async active-high reset
//            pix_en            - pixel advance enable
//            sources           - packed pixels, source k at [k*DW +: DW]
//            video_on          - pixel is visible
//            frame_start       - first pixel of a frame (with pix_en)
//            sel_in, sel_load  - source request and capture strobe
//            y, video_on_out   - registered pixel and aligned visibility
//            active_sel        - source currently driving y
//            sel_pending       - a request is waiting for frame start
//            sel_ack, sel_err  - one-clk pulses: request applied / rejected
// Revision : 1.0 - initial release
// ============================================================================
module vga_source_mux #(
    parameter  int DATA_WIDTH  = 24,
    parameter  int NUM_SOURCES = 4,
    localparam int SEL_WIDTH   = $clog2(NUM_SOURCES)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              pix_en,
    input  logic [NUM_SOURCES*DATA_WIDTH-1:0] sources,
    input  logic                              video_on,
    input  logic                              frame_start,
    input  logic [SEL_WIDTH-1:0]              sel_in,
    input  logic                              sel_load,
    output logic [DATA_WIDTH-1:0]             y,
    output logic                              video_on_out,
    output logic [SEL_WIDTH-1:0]              active_sel,
    output logic                              sel_pending,
    output logic                              sel_ack,
    output logic                              sel_err
);

    // Mux table is padded to a power of two so any select value indexes a
    // defined entry; unused slots read as black and are never selected.
    localparam int                 c_slots       = 1 << SEL_WIDTH;
    localparam logic [SEL_WIDTH:0] c_num_sources = NUM_SOURCES[SEL_WIDTH:0];

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [SEL_WIDTH-1:0]   pending_sel_q, pending_sel_d;
    logic [SEL_WIDTH-1:0]   active_sel_q, active_sel_d;
    logic [DATA_WIDTH-1:0]  y_q, y_d;
    logic                   video_on_out_q, video_on_out_d;
    logic                   sel_ack_q, sel_ack_d;
    logic                   sel_err_q, sel_err_d;

    logic [DATA_WIDTH-1:0]  src_arr [c_slots];
    logic                   valid_load;
    logic                   invalid_load;
    logic                   eff_pending;
    logic [SEL_WIDTH-1:0]   eff_sel;
    logic                   apply;
    logic [SEL_WIDTH-1:0]   mux_sel;

    generate
        for (genvar k = 0; k < c_slots; k++) begin : g_src
            if (k < NUM_SOURCES) begin : g_used
                assign src_arr[k] = sources[k*DATA_WIDTH +: DATA_WIDTH];
            end else begin : g_unused
                assign src_arr[k] = '0;
            end
        end
    endgenerate

    always_comb begin
        valid_load   = sel_load && ({1'b0, sel_in} < c_num_sources);
        invalid_load = sel_load && !valid_load;

        // A load arriving on the frame-start pixel takes effect immediately
        // rather than waiting a whole frame.
        eff_pending  = valid_load || (state_q == ST_PENDING);
        eff_sel      = valid_load ? sel_in : pending_sel_q;
        apply        = pix_en && frame_start && eff_pending;
        mux_sel      = apply ? eff_sel : active_sel_q;

        state_d        = state_q;
        pending_sel_d  = pending_sel_q;
        active_sel_d   = active_sel_q;
        y_d            = y_q;
        video_on_out_d = video_on_out_q;
        sel_ack_d      = apply;
        sel_err_d      = invalid_load;

        if (valid_load) begin
            // Last request before frame start wins.
            pending_sel_d = sel_in;
            state_d       = ST_PENDING;
        end

        if (apply) begin
            active_sel_d = eff_sel;
            state_d      = ST_IDLE;
        end

        if (pix_en) begin
            y_d            = video_on ? src_arr[mux_sel] : '0;
            video_on_out_d = video_on;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            pending_sel_q  <= '0;
            active_sel_q   <= '0;
            y_q            <= '0;
            video_on_out_q <= 1'b0;
            sel_ack_q      <= 1'b0;
            sel_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            pending_sel_q  <= pending_sel_d;
            active_sel_q   <= active_sel_d;
            y_q            <= y_d;
            video_on_out_q <= video_on_out_d;
            sel_ack_q      <= sel_ack_d;
            sel_err_q      <= sel_err_d;
        end
    end

    assign y            = y_q;
    assign video_on_out = video_on_out_q;
    assign active_sel   = active_sel_q;
    assign sel_pending  = (state_q == ST_PENDING);
    assign sel_ack      = sel_ack_q;
    assign sel_err      = sel_err_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_source_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_source_mux
// Purpose  : Self-checking bench for vga_source_mux. Pixel outputs go through
//            a scoreboard queue; control flags are compared in-line.
//            A second instance with three sources covers the rejected-select
//            path.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_source_mux;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pix_en = 1'b0;
    logic        video_on = 1'b0;
    logic        frame_start = 1'b0;
    logic [1:0]  sel_in = '0;
    logic        sel_load = 1'b0;
    logic [23:0] src [4];
    logic [95:0] sources;
    logic [23:0] y;
    logic        video_on_out;
    logic [1:0]  active_sel;
    logic        sel_pending, sel_ack, sel_err;

    // three-source instance
    logic [1:0]  sel_in2 = '0;
    logic        sel_load2 = 1'b0;
    logic [71:0] sources2;
    logic [23:0] y2;
    logic        video_on_out2;
    logic [1:0]  active_sel2;
    logic        sel_pending2, sel_ack2, sel_err2;

    int          n_vec = 0;
    int          n_err = 0;
    logic        pe_prev;
    logic [24:0] sb [$];

    assign sources  = {src[3], src[2], src[1], src[0]};
    assign sources2 = {src[2], src[1], src[0]};

    always #5 clk = ~clk;

    vga_source_mux #(.DATA_WIDTH(24), .NUM_SOURCES(4)) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en), .sources(sources),
        .video_on(video_on), .frame_start(frame_start), .sel_in(sel_in),
        .sel_load(sel_load), .y(y), .video_on_out(video_on_out),
        .active_sel(active_sel), .sel_pending(sel_pending),
        .sel_ack(sel_ack), .sel_err(sel_err)
    );

    vga_source_mux #(.DATA_WIDTH(24), .NUM_SOURCES(3)) dut3 (
        .clk(clk), .reset(reset), .pix_en(pix_en), .sources(sources2),
        .video_on(video_on), .frame_start(frame_start), .sel_in(sel_in2),
        .sel_load(sel_load2), .y(y2), .video_on_out(video_on_out2),
        .active_sel(active_sel2), .sel_pending(sel_pending2),
        .sel_ack(sel_ack2), .sel_err(sel_err2)
    );

    // A pixel is presented one clock after a cycle with pix_en=1.
    always @(posedge clk or posedge reset) begin
        if (reset) pe_prev <= 1'b0;
        else       pe_prev <= pix_en;
    end

    always @(negedge clk) begin
        if (pe_prev) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL pixel: output seen with empty scoreboard, y=%h", y);
            end else begin
                logic [24:0] e;
                e = sb.pop_front();
                if ({y, video_on_out} !== e) begin
                    n_err++;
                    $display("FAIL pixel @%0t: got y=%h von=%b, want y=%h von=%b",
                             $time, y, video_on_out, e[24:1], e[0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h, want %h", name, $time, act, exp);
        end
    endtask

    // Apply one vector for one clock; returns just after the capturing edge.
    task automatic drv(input logic pe, input logic von, input logic fs,
                       input logic [1:0] sel, input logic ld, input logic [23:0] ey);
        pix_en      = pe;
        video_on    = von;
        frame_start = fs;
        sel_in      = sel;
        sel_load    = ld;
        if (pe) sb.push_back({ey, von});
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        src[0] = 24'hFF0000; src[1] = 24'hAA55CC;
        src[2] = 24'h00FF00; src[3] = 24'h0000FF;
        pix_en = 1'b1; video_on = 1'b1; frame_start = 1'b1;
        sel_in = 2'd2; sel_load = 1'b1; sel_in2 = 2'd3; sel_load2 = 1'b1;

        // Reset asserted before any clock edge: outputs must clear at once.
        #2 reset = 1'b1;
        #1;
        chk("rst_y",       32'(y),            32'h0);
        chk("rst_von",     32'(video_on_out), 32'h0);
        chk("rst_active",  32'(active_sel),   32'h0);
        chk("rst_pending", 32'(sel_pending),  32'h0);
        chk("rst_ack",     32'(sel_ack),      32'h0);
        chk("rst_err",     32'(sel_err),      32'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        sel_load2 = 1'b0;

        // First pixel after release; three-source instance takes request 2.
        sel_in2 = 2'd2; sel_load2 = 1'b1;
        drv(1, 1, 0, 2'd0, 0, 24'hFF0000);
        chk("dut3_pend_valid", 32'(sel_pending2), 32'h1);
        chk("dut3_err_valid",  32'(sel_err2),     32'h0);

        // Blanking and latency; out-of-range select on the three-source unit.
        src[0] = 24'h123456;
        sel_in2 = 2'd3; sel_load2 = 1'b1;
        drv(1, 1, 0, 2'd0, 0, 24'h123456);
        chk("dut3_err_pulse",  32'(sel_err2),     32'h1);
        chk("dut3_pend_kept",  32'(sel_pending2), 32'h1);
        chk("dut3_active",     32'(active_sel2),  32'h0);
        chk("dut3_no_ack",     32'(sel_ack2),     32'h0);
        sel_load2 = 1'b0;
        drv(1, 0, 0, 2'd0, 0, 24'h000000);
        chk("dut3_err_clear",  32'(sel_err2),     32'h0);
        drv(1, 1, 0, 2'd0, 0, 24'h123456);

        // Deferred switch to source 2.
        drv(1, 1, 0, 2'd2, 1, 24'h123456);
        chk("defer_pending",   32'(sel_pending), 32'h1);
        chk("defer_active",    32'(active_sel),  32'h0);
        chk("defer_err",       32'(sel_err),     32'h0);
        drv(1, 1, 0, 2'd0, 0, 24'h123456);
        chk("defer_no_ack",    32'(sel_ack),     32'h0);
        drv(1, 0, 0, 2'd0, 0, 24'h000000);
        drv(1, 1, 1, 2'd0, 0, 24'h00FF00);
        chk("defer_active2",   32'(active_sel),  32'h2);
        chk("defer_ack",       32'(sel_ack),     32'h1);
        chk("defer_pend_clr",  32'(sel_pending), 32'h0);
        drv(1, 1, 0, 2'd0, 0, 24'h00FF00);
        chk("defer_ack_once",  32'(sel_ack),     32'h0);

        // Overwrite: 1 then 3, source 3 wins.
        drv(1, 1, 0, 2'd1, 1, 24'h00FF00);
        drv(1, 1, 0, 2'd3, 1, 24'h00FF00);
        chk("ovr_pending",     32'(sel_pending), 32'h1);
        chk("ovr_active_hold", 32'(active_sel),  32'h2);
        drv(1, 1, 1, 2'd0, 0, 24'h0000FF);
        chk("ovr_active",      32'(active_sel),  32'h3);
        chk("ovr_ack",         32'(sel_ack),     32'h1);

        // Load coincident with frame start applies immediately.
        drv(1, 1, 1, 2'd1, 1, 24'hAA55CC);
        chk("coin_active",     32'(active_sel),  32'h1);
        chk("coin_ack",        32'(sel_ack),     32'h1);
        chk("coin_pending",    32'(sel_pending), 32'h0);

        // Re-selecting the active source is acked, pixel unchanged.
        drv(1, 1, 0, 2'd1, 1, 24'hAA55CC);
        drv(1, 1, 1, 2'd0, 0, 24'hAA55CC);
        chk("resel_ack",       32'(sel_ack),     32'h1);
        chk("resel_active",    32'(active_sel),  32'h1);

        // frame_start without pix_en is ignored.
        drv(1, 1, 0, 2'd2, 1, 24'hAA55CC);
        drv(0, 1, 1, 2'd0, 0, 24'h000000);
        chk("fs_noen_active",  32'(active_sel),  32'h1);
        chk("fs_noen_pending", 32'(sel_pending), 32'h1);
        chk("fs_noen_ack",     32'(sel_ack),     32'h0);

        // pix_en low: outputs frozen while the selected source changes.
        for (int i = 0; i < 5; i++) begin
            src[1] = 24'h010101 * (i + 1);
            drv(0, i[0], 0, 2'd0, 0, 24'h000000);
            chk("frozen_y",    32'(y),            32'hAA55CC);
            chk("frozen_von",  32'(video_on_out), 32'h1);
        end
        src[1] = 24'hAA55CC;
        drv(1, 1, 1, 2'd0, 0, 24'h00FF00);
        chk("gate_apply",      32'(active_sel),  32'h2);
        chk("gate_ack",        32'(sel_ack),     32'h1);

        // Reset with a request pending discards it.
        drv(1, 1, 0, 2'd3, 1, 24'h00FF00);
        chk("rreq_pending",    32'(sel_pending), 32'h1);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("rreq_pend_clr",   32'(sel_pending), 32'h0);
        chk("rreq_active",     32'(active_sel),  32'h0);
        chk("rreq_y",          32'(y),           32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        drv(1, 1, 1, 2'd0, 0, 24'h123456);
        chk("rreq_no_ack",     32'(sel_ack),     32'h0);
        chk("rreq_active2",    32'(active_sel),  32'h0);

        pix_en = 1'b0; sel_load = 1'b0; frame_start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("sb_drained", 32'(sb.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
